vend_dispenser: RTL and testbench

- Output-side actuator controller for the vending machine.
- Takes one dispense order per transaction (product yes/no, plus N change coins of 5 rupees) and drives the product motor and coin hopper with timed pulses.
- Confirms each item via a sensor, tracks hopper coin stock, and reports done or a sticky fault to the vending FSM.

---
 rtl/vend_dispenser.sv | 248 ++++++++++++++++++++++++
 tb/tb_vend_dispenser.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispenser.sv
// vend_dispenser: output-side actuator controller for the vending machine.
// Takes one dispense order at a time (optional product plus N five-rupee
// coins), drives the product motor and coin hopper with fixed-width pulses,
// confirms each item through its sensor, tracks the hopper coin stock, and
// reports either a one-cycle done pulse or a sticky fault.
//
// Build option:
//   VEND_RETRY_EN - when defined, the first sensor timeout on an item
//                   re-issues that item's pulse once before faulting.
//                   When undefined, the first timeout faults immediately
//                   and no retry flag exists.
module vend_dispenser #(
  parameter int CHANGE_W    = 2,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int HOPPER_MAX  = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_product,
  input  logic [CHANGE_W-1:0]               req_change,
  output logic                              motor_out,
  input  logic                              product_sensed,
  output logic                              coin_release,
  input  logic                              coin_sensed,
  input  logic                              refill,
  input  logic                              fault_clr,
  output logic                              busy,
  output logic                              done,
  output logic                              fault,
  output logic [1:0]                        fault_code,
  output logic [$clog2(HOPPER_MAX+1)-1:0]   hopper_level
);

  localparam int HW = $clog2(HOPPER_MAX + 1);
  localparam int PW = $clog2(PULSE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [HW-1:0] HOPPER_FULL  = HW'(HOPPER_MAX);
  localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] FC_NONE         = 2'b00;
  localparam logic [1:0] FC_PRODUCT_JAM  = 2'b01;
  localparam logic [1:0] FC_HOPPER_EMPTY = 2'b10;
  localparam logic [1:0] FC_COIN_JAM     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND_PULSE,
    S_VEND_WAIT,
    S_COIN_CHECK,
    S_COIN_PULSE,
    S_COIN_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t              state_reg,      state_next;
  logic [CHANGE_W-1:0] remaining_reg,  remaining_next;
  logic [HW-1:0]       hopper_reg,     hopper_next;
  logic [PW-1:0]       pulse_cnt_reg,  pulse_cnt_next;
  logic [TW-1:0]       wait_cnt_reg,   wait_cnt_next;
  logic                sensed_reg,     sensed_next;
  logic [1:0]          fault_code_reg, fault_code_next;

  logic accept;
  logic pulse_last;
  logic timeout_hit;
  logic retry_allowed;

  // An order is taken only while idle; req_ready mirrors the same condition.
  assign accept      = req_valid && (state_reg == S_IDLE);
  assign pulse_last  = (pulse_cnt_reg == PULSE_LAST);
  assign timeout_hit = (wait_cnt_reg == TIMEOUT_LAST);

`ifdef VEND_RETRY_EN
  // Set once an item has used its single retry; cleared whenever a new item
  // begins (COIN_CHECK or IDLE).
  logic retry_reg, retry_next;
  assign retry_allowed = ~retry_reg;
`else
  assign retry_allowed = 1'b0;
`endif

  // State and datapath registers; reset aborts any order in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      remaining_reg  <= '0;
      hopper_reg     <= HOPPER_FULL;
      pulse_cnt_reg  <= '0;
      wait_cnt_reg   <= '0;
      sensed_reg     <= 1'b0;
      fault_code_reg <= FC_NONE;
`ifdef VEND_RETRY_EN
      retry_reg      <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      hopper_reg     <= hopper_next;
      pulse_cnt_reg  <= pulse_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      sensed_reg     <= sensed_next;
      fault_code_reg <= fault_code_next;
`ifdef VEND_RETRY_EN
      retry_reg      <= retry_next;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next      = state_reg;
    remaining_next  = remaining_reg;
    hopper_next     = hopper_reg;
    pulse_cnt_next  = '0;
    wait_cnt_next   = '0;
    sensed_next     = 1'b0;
    fault_code_next = fault_code_reg;
`ifdef VEND_RETRY_EN
    retry_next      = retry_reg;
`endif

    case (state_reg)
      S_IDLE: begin
`ifdef VEND_RETRY_EN
        retry_next = 1'b0;
`endif
        if (accept) begin
          // Only the coin count needs to persist; the product flag is used
          // right here to pick the first step of the order.
          remaining_next = req_change;
          state_next     = req_product ? S_VEND_PULSE : S_COIN_CHECK;
        end else if (refill) begin
          hopper_next = HOPPER_FULL;
        end
      end

      S_VEND_PULSE: begin
        // A drop seen while the motor is still driven counts for the wait.
        sensed_next = sensed_reg | product_sensed;
        if (pulse_last) begin
          state_next = S_VEND_WAIT;
        end else begin
          pulse_cnt_next = pulse_cnt_reg + 1'b1;
        end
      end

      S_VEND_WAIT: begin
        if (sensed_reg || product_sensed) begin
          state_next = S_COIN_CHECK;
        end else if (timeout_hit) begin
          if (retry_allowed) begin
            state_next = S_VEND_PULSE;
`ifdef VEND_RETRY_EN
            retry_next = 1'b1;
`endif
          end else begin
            state_next      = S_FAULT;
            fault_code_next = FC_PRODUCT_JAM;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      S_COIN_CHECK: begin
`ifdef VEND_RETRY_EN
        retry_next = 1'b0;
`endif
        // Checking stock before every pulse keeps hopper_level from wrapping.
        if (remaining_reg == '0) begin
          state_next = S_DONE;
        end else if (hopper_reg == '0) begin
          state_next      = S_FAULT;
          fault_code_next = FC_HOPPER_EMPTY;
        end else begin
          state_next = S_COIN_PULSE;
        end
      end

      S_COIN_PULSE: begin
        sensed_next = sensed_reg | coin_sensed;
        if (pulse_last) begin
          state_next = S_COIN_WAIT;
        end else begin
          pulse_cnt_next = pulse_cnt_reg + 1'b1;
        end
      end

      S_COIN_WAIT: begin
        if (sensed_reg || coin_sensed) begin
          remaining_next = remaining_reg - 1'b1;
          hopper_next    = hopper_reg - 1'b1;
          state_next     = S_COIN_CHECK;
        end else if (timeout_hit) begin
          if (retry_allowed) begin
            state_next = S_COIN_PULSE;
`ifdef VEND_RETRY_EN
            retry_next = 1'b1;
`endif
          end else begin
            // The coin was never confirmed, so the stock is left untouched.
            state_next      = S_FAULT;
            fault_code_next = FC_COIN_JAM;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      S_FAULT: begin
        // The interrupted order is dropped; clearing returns to a clean idle.
        if (fault_clr) begin
          state_next      = S_IDLE;
          fault_code_next = FC_NONE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    req_ready    = (state_reg == S_IDLE);
    busy         = (state_reg == S_VEND_PULSE) || (state_reg == S_VEND_WAIT) ||
                   (state_reg == S_COIN_CHECK) || (state_reg == S_COIN_PULSE) ||
                   (state_reg == S_COIN_WAIT);
    motor_out    = (state_reg == S_VEND_PULSE);
    coin_release = (state_reg == S_COIN_PULSE);
    done         = (state_reg == S_DONE);
    fault        = (state_reg == S_FAULT);
    fault_code   = fault_code_reg;
    hopper_level = hopper_reg;
  end

endmodule

// File: tb/tb_vend_dispenser.sv
// tb_vend_dispenser: scoreboard bench for vend_dispenser. Each order pushes
// its predicted outcome; the outcome is popped and compared when the DUT
// raises done or fault. A sensor responder answers motor / coin pulses.
module tb_vend_dispenser;

  localparam int CHANGE_W    = 2;
  localparam int PULSE_CYC   = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int HOPPER_MAX  = 15;
  localparam int HW          = $clog2(HOPPER_MAX + 1);
`ifdef VEND_RETRY_EN
  localparam int TRIES = 2;
`else
  localparam int TRIES = 1;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic                req_product;
  logic [CHANGE_W-1:0] req_change;
  logic                motor_out;
  logic                product_sensed;
  logic                coin_release;
  logic                coin_sensed;
  logic                refill;
  logic                fault_clr;
  logic                busy;
  logic                done;
  logic                fault;
  logic [1:0]          fault_code;
  logic [HW-1:0]       hopper_level;

  logic prod_resp;
  logic coin_resp;
  logic coin_spur;
  bit   prod_en    = 1'b1;
  bit   coin_en    = 1'b1;
  int   prod_delay = 3;
  int   coin_delay = 2;

  assign product_sensed = prod_resp;
  assign coin_sensed    = coin_resp | coin_spur;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int model_hopper = HOPPER_MAX;

  typedef struct {
    int kind;      // 0 done, 1 fault
    int code;
    int hopper;
    int mp;        // motor pulses
    int cp;        // coin pulses
    int done_lat;  // -1 = not checked
    int jam_lat;   // -1 = not checked
  } exp_t;

  exp_t sb_q[$];

  vend_dispenser #(
    .CHANGE_W   (CHANGE_W),
    .PULSE_CYC  (PULSE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .HOPPER_MAX (HOPPER_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_product   (req_product),
    .req_change    (req_change),
    .motor_out     (motor_out),
    .product_sensed(product_sensed),
    .coin_release  (coin_release),
    .coin_sensed   (coin_sensed),
    .refill        (refill),
    .fault_clr     (fault_clr),
    .busy          (busy),
    .done          (done),
    .fault         (fault),
    .fault_code    (fault_code),
    .hopper_level  (hopper_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    total_cnt++;
    if (obs != exp_v) begin
      bad_cnt++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  // Sensor responder: one-cycle pulse a fixed delay after each drive falls.
  initial begin
    int   p_cd = -1;
    int   c_cd = -1;
    logic m_prev = 1'b0;
    logic c_prev = 1'b0;
    prod_resp = 1'b0;
    coin_resp = 1'b0;
    forever begin
      @(negedge clk);
      prod_resp = 1'b0;
      coin_resp = 1'b0;
      if (p_cd == 0) begin prod_resp = 1'b1; p_cd = -1; end
      else if (p_cd > 0) p_cd--;
      if (c_cd == 0) begin coin_resp = 1'b1; c_cd = -1; end
      else if (c_cd > 0) c_cd--;
      if (m_prev && !motor_out && prod_en) p_cd = prod_delay - 1;
      if (c_prev && !coin_release && coin_en) c_cd = coin_delay - 1;
      m_prev = motor_out;
      c_prev = coin_release;
    end
  end

  // Behavioural prediction of one order from the bench's own hopper count.
  function automatic exp_t predict(input bit prod, input int chg,
                                   input bit prod_ok, input bit coin_ok);
    exp_t e;
    int   coins;
    e.kind = 0; e.code = 0; e.mp = prod ? 1 : 0; e.cp = 0;
    e.done_lat = -1; e.jam_lat = -1; e.hopper = model_hopper;
    if (prod && !prod_ok) begin
      e.kind = 1; e.code = 1; e.mp = TRIES; e.jam_lat = TIMEOUT_CYC;
      return e;
    end
    coins = (chg <= model_hopper) ? chg : model_hopper;
    if (coins > 0 && !coin_ok) begin
      e.kind = 1; e.code = 3; e.cp = TRIES; e.jam_lat = TIMEOUT_CYC;
      return e;
    end
    e.cp     = coins;
    e.hopper = model_hopper - coins;
    if (coins < chg) begin e.kind = 1; e.code = 2; end
    if (!prod && chg == 0) e.done_lat = 2;
    return e;
  endfunction

  task automatic run_order(input string name, input bit prod, input int chg,
                           input bit prod_ok, input bit coin_ok);
    exp_t e;
    int   cyc = 0, m_run = 0, c_run = 0, m_pulses = 0, c_pulses = 0;
    int   m_fall = 0, c_fall = 0;
    logic m_prev = 1'b0, c_prev = 1'b0;
    bit   seen = 1'b0;
    prod_en = prod_ok;
    coin_en = coin_ok;
    e = predict(prod, chg, prod_ok, coin_ok);
    sb_q.push_back(e);
    @(negedge clk);
    check({name, " req_ready"}, req_ready, 1);
    req_valid   = 1'b1;
    req_product = prod;
    req_change  = CHANGE_W'(chg);
    while (!seen && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid = 1'b0;
        check({name, " busy"}, busy, 1);
      end
      if (motor_out) m_run++;
      else if (m_prev) begin
        check({name, " motor_width"}, m_run, PULSE_CYC);
        m_pulses++; m_run = 0; m_fall = cyc;
      end
      if (coin_release) c_run++;
      else if (c_prev) begin
        check({name, " coin_width"}, c_run, PULSE_CYC);
        c_pulses++; c_run = 0; c_fall = cyc;
      end
      m_prev = motor_out;
      c_prev = coin_release;
      if (done || fault) seen = 1'b1;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      check({name, " outcome_in_time"}, 0, 1);
    end else begin
      check({name, " kind"}, fault ? 1 : 0, e.kind);
      check({name, " fault_code"}, fault_code, e.code);
      check({name, " hopper"}, hopper_level, e.hopper);
      check({name, " motor_pulses"}, m_pulses, e.mp);
      check({name, " coin_pulses"}, c_pulses, e.cp);
      if (e.done_lat >= 0) check({name, " done_latency"}, cyc, e.done_lat);
      if (e.jam_lat >= 0)
        check({name, " jam_latency"}, cyc - ((e.code == 3) ? c_fall : m_fall), e.jam_lat);
    end
    $display("order %s prod=%0d chg=%0d -> done=%0d fault=%0d code=%0d hopper=%0d cycles=%0d",
             name, prod, chg, done, fault, fault_code, hopper_level, cyc);
    model_hopper = e.hopper;
    if (seen && e.kind == 0) begin
      @(negedge clk);
      check({name, " ready_after_done"}, req_ready, 1);
    end
  endtask

  // Confirms the fault is sticky and blocks orders, then clears it.
  task automatic clear_fault(input string name, input int code);
    @(negedge clk);
    req_valid = 1'b1;
    coin_spur = 1'b1;
    @(negedge clk);
    coin_spur = 1'b0;
    check({name, " fault_sticky"}, fault, 1);
    check({name, " code_held"}, fault_code, code);
    check({name, " ready_in_fault"}, req_ready, 0);
    @(negedge clk);
    check({name, " busy_in_fault"}, busy, 0);
    check({name, " hopper_in_fault"}, hopper_level, model_hopper);
    req_valid = 1'b0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check({name, " fault_cleared"}, fault, 0);
    check({name, " code_cleared"}, fault_code, 0);
    check({name, " ready_after_clr"}, req_ready, 1);
    $display("clear %s -> fault=%0d ready=%0d", name, fault, req_ready);
  endtask

  initial begin
    int wait_cyc;
    rst = 1'b1; req_valid = 1'b0; req_product = 1'b0; req_change = '0;
    refill = 1'b0; fault_clr = 1'b0; coin_spur = 1'b0;
    repeat (3) @(negedge clk);
    check("rst req_ready", req_ready, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst motor", motor_out, 0);
    check("rst coin", coin_release, 0);
    check("rst fault", fault, 0);
    check("rst code", fault_code, 0);
    check("rst hopper", hopper_level, HOPPER_MAX);
    $display("reset -> ready=%0d hopper=%0d", req_ready, hopper_level);
    rst = 1'b0;

    prod_delay = 3; coin_delay = 2;
    run_order("prod_only", 1'b1, 0, 1'b1, 1'b1);
    prod_delay = 2;
    run_order("prod_chg2", 1'b1, 2, 1'b1, 1'b1);
    run_order("empty", 1'b0, 0, 1'b1, 1'b1);

    // Spurious coin sensor in IDLE must not touch the stock.
    @(negedge clk); coin_spur = 1'b1;
    @(negedge clk); coin_spur = 1'b0;
    @(negedge clk);
    check("spur_idle hopper", hopper_level, model_hopper);
    $display("spurious coin in idle -> hopper=%0d", hopper_level);

    for (int i = 0; i < 4; i++) run_order("drain", 1'b0, 3, 1'b1, 1'b1);
    run_order("hopper_empty", 1'b0, 3, 1'b1, 1'b1);
    clear_fault("hopper_empty", 2);

    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    check("refill hopper", hopper_level, HOPPER_MAX);
    model_hopper = HOPPER_MAX;
    $display("refill -> hopper=%0d", hopper_level);

    run_order("coin_jam", 1'b0, 1, 1'b1, 1'b0);
    clear_fault("coin_jam", 3);
    run_order("prod_jam", 1'b1, 0, 1'b0, 1'b1);
    clear_fault("prod_jam", 1);

    // Reset while the first coin of a two-coin order is being released.
    prod_en = 1'b1; coin_en = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_product = 1'b0; req_change = 2'd2;
    wait_cyc = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      wait_cyc++;
    end while (!coin_release && wait_cyc < 50);
    check("rst_mid coin_seen", coin_release, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid coin", coin_release, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid hopper", hopper_level, HOPPER_MAX);
    check("rst_mid ready", req_ready, 1);
    $display("reset mid coin pulse -> coin=%0d busy=%0d hopper=%0d", coin_release, busy, hopper_level);
    rst = 1'b0;
    model_hopper = HOPPER_MAX;
    repeat (5) @(negedge clk);

    run_order("after_rst", 1'b1, 1, 1'b1, 1'b1);
    check("scoreboard empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
